// File: rtl/sine_sweep_controller.sv
// Linear phase_step sweep sequencer for the sine wave generator.
// Holds each step for max(dwell,1) clocks, walking from start_step toward
// stop_step in step_increment increments, with start/busy/done handshake
// and abort.
module sine_sweep_controller #(
  parameter int unsigned PHASE_STEP_WIDTH = 32,
  parameter int unsigned DWELL_WIDTH      = 32,
  parameter bit          PARK_AT_ZERO     = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  input  logic [PHASE_STEP_WIDTH-1:0] start_step,
  input  logic [PHASE_STEP_WIDTH-1:0] stop_step,
  input  logic [PHASE_STEP_WIDTH-1:0] step_increment,
  input  logic [DWELL_WIDTH-1:0]      dwell_cycles,
  output logic [PHASE_STEP_WIDTH-1:0] phase_step,
  output logic                        step_strobe,
  output logic [15:0]                 step_index,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DWELL  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                      state_q,   state_d;
  logic [PHASE_STEP_WIDTH-1:0] phase_q,   phase_d;
  logic [PHASE_STEP_WIDTH-1:0] stop_q,    stop_d;
  logic [PHASE_STEP_WIDTH-1:0] inc_q,     inc_d;
  logic [DWELL_WIDTH-1:0]      reload_q,  reload_d;
  logic [DWELL_WIDTH-1:0]      cnt_q,     cnt_d;
  logic [15:0]                 index_q,   index_d;
  logic                        strobe_q,  strobe_d;
  logic                        busy_q,    busy_d;
  logic                        done_q,    done_d;
  logic                        aborted_q, aborted_d;

  logic [PHASE_STEP_WIDTH:0]   next_sum;
  logic [DWELL_WIDTH-1:0]      dwell_reload;

  // Next-state and registered-output logic for the sweep sequencer.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    stop_d    = stop_q;
    inc_d     = inc_q;
    reload_d  = reload_q;
    cnt_d     = cnt_q;
    index_d   = index_q;
    strobe_d  = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;

    // One extra bit so a carry out of the phase width ends the sweep.
    next_sum     = {1'b0, phase_q} + {1'b0, inc_q};
    // Counter holds remaining cycles minus one; dwell of 0 behaves as 1.
    dwell_reload = (dwell_cycles == '0) ? '0 : dwell_cycles - DWELL_WIDTH'(1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          stop_d    = stop_step;
          inc_d     = step_increment;
          reload_d  = dwell_reload;
          cnt_d     = dwell_reload;
          phase_d   = start_step;
          strobe_d  = 1'b1;
          busy_d    = 1'b1;
          index_d   = '0;
          aborted_d = 1'b0;
          state_d   = DWELL;
        end
      end

      DWELL: begin
        if (abort) begin
          state_d   = FINISH;
          aborted_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          if (PARK_AT_ZERO) phase_d = '0;
        end else if (cnt_q == '0) begin
          if ((inc_q == '0) || next_sum[PHASE_STEP_WIDTH] ||
              (next_sum[PHASE_STEP_WIDTH-1:0] > stop_q)) begin
            state_d   = FINISH;
            aborted_d = 1'b0;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            if (PARK_AT_ZERO) phase_d = '0;
          end else begin
            phase_d  = next_sum[PHASE_STEP_WIDTH-1:0];
            strobe_d = 1'b1;
            index_d  = (index_q == 16'hFFFF) ? index_q : index_q + 16'd1;
            cnt_d    = reload_q;
          end
        end else begin
          cnt_d = cnt_q - DWELL_WIDTH'(1);
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      stop_q    <= '0;
      inc_q     <= '0;
      reload_q  <= '0;
      cnt_q     <= '0;
      index_q   <= '0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      stop_q    <= stop_d;
      inc_q     <= inc_d;
      reload_q  <= reload_d;
      cnt_q     <= cnt_d;
      index_q   <= index_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign phase_step  = phase_q;
  assign step_strobe = strobe_q;
  assign step_index  = index_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;

endmodule
